// File: rtl/pacman_pkg.sv
// Shared playfield geometry, heading codes and mover state for the player and ghost blocks.
package pacman_pkg;

   localparam int WIDTH        = 640;
   localparam int HEIGHT       = 480;
   localparam int tile_size    = 20;
   localparam int tile_col_num = WIDTH / tile_size;
   localparam int tile_row_num = HEIGHT / tile_size;
   localparam int TILE_NUM     = tile_row_num * tile_col_num;

   localparam logic [1:0] dir_up    = 2'd0;
   localparam logic [1:0] dir_down  = 2'd1;
   localparam logic [1:0] dir_left  = 2'd2;
   localparam logic [1:0] dir_right = 2'd3;

   typedef enum logic [1:0] {
      ALIVE = 2'd0,
      DYING = 2'd1,
      OVER  = 2'd2
   } mover_state_e;

   // Row-major tile number of the tile containing pixel (x, y).
   function automatic int tile_index(input int x, input int y);
      return (WIDTH / tile_size) * (y / tile_size) + (x / tile_size);
   endfunction

endpackage

// File: rtl/pacman_if.sv
// Player bus: keypad/map/event inputs into the mover and the player state it publishes to the ghosts.
interface pacman_if import pacman_pkg::*; #(parameter int LIVES = 3);

   logic                           w;
   logic                           a;
   logic                           s;
   logic                           d;
   logic [TILE_NUM-1:0]            tilemap_walls;
   logic                           power_pellet;
   logic                           ghost_hit;
   logic [$clog2(WIDTH)-1:0]       player_x;
   logic [$clog2(HEIGHT)-1:0]      player_y;
   logic [1:0]                     player_dir;
   logic                           moving;
   logic                           step;
   logic                           frighten;
   logic [$clog2(LIVES+1)-1:0]     lives;
   logic                           game_over;

   modport master (
      input  w, a, s, d, tilemap_walls, power_pellet, ghost_hit,
      output player_x, player_y, player_dir, moving, step, frighten, lives, game_over
   );

   modport slave (
      output w, a, s, d, tilemap_walls, power_pellet, ghost_hit,
      input  player_x, player_y, player_dir, moving, step, frighten, lives, game_over
   );

endinterface

// File: rtl/move_tick_gen.sv
// Divides clk down to a one-cycle move tick every TICK_DIV cycles (TICK_DIV >= 2).
module move_tick_gen #(
   parameter int TICK_DIV = 400000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] cnt_r;
   logic          tick_r;

   // Free-running divider; tick_r is set on the edge that brings the counter to its last value.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r  <= '0;
         tick_r <= 1'b0;
      end else begin
         if (cnt_r == CW'(TICK_DIV - 1)) begin
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
         tick_r <= (cnt_r == CW'(TICK_DIV - 2));
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/pacman_mover.sv
// Player movement, frighten countdown, ghost collisions, lives and game-over handling.
module pacman_mover import pacman_pkg::*; #(
   parameter int SPEED        = 1,
   parameter int TICK_DIV     = 400000,
   parameter int START_X      = 310,
   parameter int START_Y      = 350,
   parameter int BOUND_X0     = 0,
   parameter int BOUND_X1     = 620,
   parameter int BOUND_Y0     = 0,
   parameter int BOUND_Y1     = 460,
   parameter int FRIGHT_TICKS = 600,
   parameter int DEATH_TICKS  = 120,
   parameter int LIVES        = 3
) (
   input  logic     clk,
   input  logic     rst,
   pacman_if.master bus
);

   localparam int X_W   = $clog2(WIDTH);
   localparam int Y_W   = $clog2(HEIGHT);
   localparam int IDX_W = $clog2(TILE_NUM);
   localparam int LV_W  = $clog2(LIVES + 1);
   localparam int FR_W  = (FRIGHT_TICKS < 1) ? 1 : $clog2(FRIGHT_TICKS + 1);
   localparam int DT_W  = (DEATH_TICKS < 1) ? 1 : $clog2(DEATH_TICKS + 1);

   mover_state_e    state_r;
   logic [X_W-1:0]  x_r;
   logic [Y_W-1:0]  y_r;
   logic [1:0]      player_dir_r;
   logic [1:0]      req_dir_r;
   logic            moving_r;
   logic            step_r;
   logic            frighten_r;
   logic [FR_W-1:0] fright_cnt_r;
   logic [DT_W-1:0] death_cnt_r;
   logic [LV_W-1:0] lives_r;
   logic            game_over_r;

   logic            tick_s;
   logic [1:0]      key_dir_s;
   logic [1:0]      move_dir_s;
   logic            req_ok_s;
   logic            cur_ok_s;
   logic [X_W-1:0]  nx_s;
   logic [Y_W-1:0]  ny_s;
   logic [FR_W-1:0] fright_nxt_s;

   move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_s)
   );

   // Underflow, bounds and open-tile test for one SPEED step in direction dir.
   function automatic logic dir_legal(input logic [1:0] dir, input logic [X_W-1:0] x,
                                      input logic [Y_W-1:0] y, input logic [TILE_NUM-1:0] walls);
      int             nx;
      int             ny;
      logic           ok;
      logic [IDX_W-1:0] idx;
      nx  = int'(x);
      ny  = int'(y);
      ok  = 1'b1;
      idx = '0;
      case (dir)
         dir_up:    if (ny < SPEED) ok = 1'b0; else ny = ny - SPEED;
         dir_down:  ny = ny + SPEED;
         dir_left:  if (nx < SPEED) ok = 1'b0; else nx = nx - SPEED;
         dir_right: nx = nx + SPEED;
         default:   ok = 1'b0;
      endcase
      if (nx < BOUND_X0 || nx > BOUND_X1 || ny < BOUND_Y0 || ny > BOUND_Y1) begin
         ok = 1'b0;
      end else if (nx >= WIDTH || ny >= HEIGHT) begin
         ok = 1'b0;
      end else begin
         idx = IDX_W'(tile_index(nx, ny));
         if (!walls[idx]) ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic [X_W-1:0] move_x(input logic [1:0] dir, input logic [X_W-1:0] x);
      case (dir)
         dir_left:  return x - X_W'(SPEED);
         dir_right: return x + X_W'(SPEED);
         default:   return x;
      endcase
   endfunction

   function automatic logic [Y_W-1:0] move_y(input logic [1:0] dir, input logic [Y_W-1:0] y);
      case (dir)
         dir_up:   return y - Y_W'(SPEED);
         dir_down: return y + Y_W'(SPEED);
         default:  return y;
      endcase
   endfunction

   // Requested heading takes precedence; otherwise keep going straight.
   always_comb begin
      req_ok_s = dir_legal(req_dir_r, x_r, y_r, bus.tilemap_walls);
      cur_ok_s = dir_legal(player_dir_r, x_r, y_r, bus.tilemap_walls);
      if (req_ok_s) begin
         move_dir_s = req_dir_r;
      end else begin
         move_dir_s = player_dir_r;
      end
      nx_s = move_x(move_dir_s, x_r);
      ny_s = move_y(move_dir_s, y_r);
   end

   // Key priority latch and next frighten count (a reload beats a same-cycle decrement).
   always_comb begin
      key_dir_s = req_dir_r;
      if (bus.w) begin
         key_dir_s = dir_up;
      end else if (bus.a) begin
         key_dir_s = dir_left;
      end else if (bus.s) begin
         key_dir_s = dir_down;
      end else if (bus.d) begin
         key_dir_s = dir_right;
      end else begin
         key_dir_s = req_dir_r;
      end

      fright_nxt_s = fright_cnt_r;
      case (state_r)
         ALIVE: begin
            if (bus.ghost_hit && !frighten_r) begin
               fright_nxt_s = '0;
            end else if (bus.power_pellet) begin
               fright_nxt_s = FR_W'(FRIGHT_TICKS);
            end else if (tick_s && frighten_r) begin
               fright_nxt_s = fright_cnt_r - FR_W'(1);
            end else begin
               fright_nxt_s = fright_cnt_r;
            end
         end
         DYING:   fright_nxt_s = '0;
         default: fright_nxt_s = fright_cnt_r;
      endcase
   end

   // Life-cycle FSM with all player outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ALIVE;
         x_r          <= X_W'(START_X);
         y_r          <= Y_W'(START_Y);
         player_dir_r <= dir_left;
         req_dir_r    <= dir_left;
         moving_r     <= 1'b0;
         step_r       <= 1'b0;
         frighten_r   <= 1'b0;
         fright_cnt_r <= '0;
         death_cnt_r  <= '0;
         lives_r      <= LV_W'(LIVES);
         game_over_r  <= 1'b0;
      end else begin
         req_dir_r    <= key_dir_s;
         fright_cnt_r <= fright_nxt_s;
         frighten_r   <= (fright_nxt_s != '0);
         step_r       <= 1'b0;
         case (state_r)
            ALIVE: begin
               if (bus.ghost_hit && !frighten_r) begin
                  state_r     <= DYING;
                  moving_r    <= 1'b0;
                  death_cnt_r <= DT_W'(DEATH_TICKS);
                  if (lives_r != '0) begin
                     lives_r <= lives_r - LV_W'(1);
                  end
               end else if (tick_s) begin
                  if (req_ok_s || cur_ok_s) begin
                     player_dir_r <= move_dir_s;
                     x_r          <= nx_s;
                     y_r          <= ny_s;
                     moving_r     <= 1'b1;
                     step_r       <= 1'b1;
                  end else begin
                     moving_r <= 1'b0;
                  end
               end
            end
            DYING: begin
               if (tick_s) begin
                  if (death_cnt_r <= DT_W'(1)) begin
                     death_cnt_r <= '0;
                     if (lives_r == '0) begin
                        state_r     <= OVER;
                        game_over_r <= 1'b1;
                     end else begin
                        state_r      <= ALIVE;
                        x_r          <= X_W'(START_X);
                        y_r          <= Y_W'(START_Y);
                        player_dir_r <= dir_left;
                     end
                  end else begin
                     death_cnt_r <= death_cnt_r - DT_W'(1);
                  end
               end
            end
            OVER:    state_r <= OVER;
            default: state_r <= ALIVE;
         endcase
      end
   end

   assign bus.player_x   = x_r;
   assign bus.player_y   = y_r;
   assign bus.player_dir = player_dir_r;
   assign bus.moving     = moving_r;
   assign bus.step       = step_r;
   assign bus.frighten   = frighten_r;
   assign bus.lives      = lives_r;
   assign bus.game_over  = game_over_r;

endmodule

// File: doc/pacman_mover.md
Name: pacman_mover

Overview:
- Player-side counterpart of the ghost AI. The ghost reads player_x/player_y and keys; this block produces them.
- Turns w/a/s/d key levels into a buffered turn request. Moves Pac-Man through the tile map on a divided move tick.
- Runs the frighten countdown that the ghosts consume.
- Handles ghost collisions, lives, respawn and game over.
- Sits between the keypad inputs and all ghost instances.

Parameters:
- SPEED, 1: pixels moved per move tick.
- TICK_DIV, 400000: clk cycles per move tick; must be >= 2.
- START_X, 310: spawn and respawn x.
- START_Y, 350: spawn and respawn y.
- BOUND_X0, 0 / BOUND_X1, 620 / BOUND_Y0, 0 / BOUND_Y1, 460: inclusive position limits.
- FRIGHT_TICKS, 600: move ticks that frighten stays asserted after a power pellet.
- DEATH_TICKS, 120: move ticks spent frozen in DYING.
- LIVES, 3: initial life count; must be >= 1.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- w, a, s, d, in, 1 each: key levels.
- tilemap_walls, in, `tile_row_num*`tile_col_num: bit = 1 means the tile is open (walkable).
- power_pellet, in, 1: one-cycle pulse from the pellet logic.
- ghost_hit, in, 1: level; some ghost overlaps the player this cycle.
- player_x, out, $clog2(`WIDTH): player x position.
- player_y, out, $clog2(`HEIGHT): player y position.
- player_dir, out, 2: current heading, `dir_* encoding.
- moving, out, 1: last move tick produced motion.
- step, out, 1: one-cycle pulse when the position changes.
- frighten, out, 1: frighten countdown nonzero.
- lives, out, $clog2(LIVES+1): remaining lives.
- game_over, out, 1: sticky; asserted when lives are exhausted.

Behaviour:
- Reset state:
  - player_x=START_X, player_y=START_Y.
  - player_dir=`dir_left, req_dir=`dir_left.
  - moving=0, step=0, frighten=0 (counter 0), lives=LIVES, game_over=0.
  - state=ALIVE, tick counter=0.
  - rst mid-DYING or mid-frighten aborts to these values on the next edge.
- Tick:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly one cycle when counter==TICK_DIV-1.
- Key latch, every cycle, in every state:
  - Priority w>a>s>d sets req_dir to up/left/down/right respectively.
  - No key held: req_dir holds its value. A released key is not forgotten.
- Candidate legality for direction D from (x,y):
  - Next position is x±SPEED or y±SPEED.
  - Illegal if the subtraction underflows (x<SPEED or y<SPEED).
  - Illegal if the next position is outside [BOUND_*0, BOUND_*1].
  - Illegal if tilemap_walls[(`WIDTH/`tile_size)*(ny/`tile_size) + nx/`tile_size] == 0.
  - Checks are combinational on registered state; no extra latency.
- ALIVE on tick, first match wins:
  1. req_dir legal: player_dir<=req_dir, move, moving<=1, step pulses next cycle.
  2. Else player_dir legal: move, moving<=1, step pulses.
  3. Else: hold position, moving<=0, player_dir unchanged.
- Position registers change only on tick edges. Latency from key press to movement is at most TICK_DIV cycles.
- Frighten counter:
  - A power_pellet pulse in ALIVE loads FRIGHT_TICKS. A pulse during an active countdown reloads it.
  - Otherwise the counter decrements on each tick while nonzero.
  - If load and tick coincide, load wins and there is no decrement.
  - frighten = (counter != 0).
  - power_pellet is ignored in DYING and OVER.
- ALIVE with ghost_hit=1:
  - frighten=1: hit is ignored; the ghost handles its own death. Movement continues.
  - frighten=0: go to DYING, lives<=lives-1, moving<=0, frighten counter cleared, death counter<=DEATH_TICKS.
  - Hit and tick in the same cycle: the hit wins and no move occurs.
- DYING:
  - Position frozen; death counter decrements per tick; ghost_hit ignored.
  - On the tick where the counter reaches 0 and lives==0: go to OVER, game_over<=1.
  - Otherwise: position<=START, player_dir<=`dir_left, req_dir unchanged, go to ALIVE.
- OVER: everything frozen and outputs held until rst.
- lives never wraps below 0.

Decomposition:
- Shared package pacman_pkg holds:
  - `dir_up/`dir_down/`dir_left/`dir_right codes.
  - WIDTH, HEIGHT, tile_size, tile_row_num, tile_col_num.
  - A tile_index(x,y) function, reused by the ghost modules.
  - The state enum ALIVE/DYING/OVER.
- One sub-module, move_tick_gen (parameter TICK_DIV; ports clk, rst, tick). Ghosts reuse it.

Test Plan:
- Bench uses TICK_DIV=4, SPEED=1, open corridor along y=350.
- Reset, no keys, 3 ticks -> x 310→309→308→307, y=350, player_dir=left, a step pulse per tick.
- Wall ahead at x=299 column, d pressed one cycle then released at x=300 -> heading right, x moves to 301. Then force walls left and right -> moving=0, x held, player_dir held.
- Request up where the up tile is closed, current heading left open -> x keeps decrementing. When the up tile opens -> player_dir=up, y decrements on the next tick.
- power_pellet pulse with FRIGHT_TICKS=5 -> frighten=1 for exactly 5 ticks. A second pulse at tick 3 -> 5 more ticks from there. ghost_hit during frighten -> lives stays 3.
- ghost_hit with frighten=0, DEATH_TICKS=2 -> lives=2, position frozen 2 ticks, then x=310, y=350, player_dir=left.
- Three unfrightened hits -> lives=0, game_over=1 after the final DYING. rst -> lives=3, game_over=0, x=310.
